sdram_mp_arbiter: RTL and testbench

Single-clock, parametrised N-port arbiter that sits directly in front of `sdram_ctrl`'s internal access interface (`acc`/`ack`/`we`/`adr`/`dat`/`sel`, 16-bit). It generalises the fixed wishbone front-end in three ways:
- configurable port count;
- selectable round-robin or fixed-priority arbitration;
- 32-bit to two-beat 16-bit width conversion.

It serves masters already in the SDRAM clock domain, with no CDC buffering.

---
 rtl/sdram_mp_arbiter.sv | 103 ++++++++++
 tb/tb_sdram_mp_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_mp_arbiter.sv
// sdram_mp_arbiter: N-port round-robin/fixed-priority front-end for sdram_ctrl,
// splitting each 32-bit master access into two big-endian 16-bit beats.
module sdram_mp_arbiter #(
  parameter int    PORTS    = 4,
  parameter string ARB_MODE = "RR"
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst_n,
  input  logic [PORTS-1:0]      req_i,
  input  logic [PORTS-1:0]      we_i,
  input  logic [PORTS*32-1:0]   adr_i,
  input  logic [PORTS*32-1:0]   wdat_i,
  input  logic [PORTS*4-1:0]    sel_i,
  output logic [PORTS-1:0]      ack_o,
  output logic [31:0]           rdat_o,
  output logic [PORTS-1:0]      gnt_o,
  input  logic                  idle_i,
  output logic                  acc_o,
  output logic                  we_o,
  output logic [31:0]           adr_o,
  output logic [15:0]           dat_o,
  output logic [1:0]            sel_o,
  input  logic                  ack_i,
  input  logic [15:0]           dat_i
);
  localparam int IW = PORTS > 1 ? $clog2(PORTS) : 1;
  localparam bit RR = ARB_MODE == "RR";
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr, g, win, base, off;
  logic [IW:0] sum;
  logic [PORTS-1:0] rot;
  logic [15:0] wdat_lo, rd_hi;
  logic [1:0] sel_lo;
  logic start;
  // Rotate requests so the scan starts at the pointer, then pick the lowest set bit.
  always_comb begin
    base = RR ? rr : '0;
    rot = PORTS'({req_i, req_i} >> base);
    off = '0;
    for (int i = PORTS - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    sum = {1'b0, base} + {1'b0, off};
    win = IW'(sum >= (IW+1)'(PORTS) ? sum - (IW+1)'(PORTS) : sum);
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = idle_i && |req_i ? BEAT0 : IDLE;
      BEAT0:   state_d = ack_i ? BEAT1 : BEAT0;
      BEAT1:   state_d = ack_i ? RESP : BEAT1;
      default: state_d = IDLE;
    endcase
  end
  assign start = state == IDLE && state_d == BEAT0;
  always_ff @(posedge sdram_clk or negedge sdram_rst_n)
    if (!sdram_rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge sdram_clk or negedge sdram_rst_n)
    if (!sdram_rst_n) begin
      rr      <= '0;
      g       <= '0;
      rd_hi   <= '0;
      wdat_lo <= '0;
      sel_lo  <= '0;
      ack_o   <= '0;
      gnt_o   <= '0;
      rdat_o  <= '0;
      acc_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      sel_o   <= '0;
    end else begin
      ack_o <= '0;
      if (start) begin
        g       <= win;
        gnt_o   <= PORTS'(1) << win;
        we_o    <= we_i[win];
        adr_o   <= adr_i[win*32 +: 32] & 32'hFFFF_FFFC;
        dat_o   <= wdat_i[win*32+16 +: 16];
        sel_o   <= sel_i[win*4+2 +: 2];
        wdat_lo <= wdat_i[win*32 +: 16];
        sel_lo  <= sel_i[win*4 +: 2];
        acc_o   <= 1'b1;
      end
      if (state == BEAT0 && ack_i) begin
        rd_hi    <= we_o ? rd_hi : dat_i;
        adr_o[1] <= 1'b1;
        dat_o    <= wdat_lo;
        sel_o    <= sel_lo;
      end
      if (state == BEAT1 && ack_i) begin
        ack_o  <= gnt_o;
        rdat_o <= we_o ? rdat_o : {rd_hi, dat_i};
        acc_o  <= 1'b0;
        we_o   <= 1'b0;
      end
      if (state == RESP) begin
        gnt_o <= '0;
        rr    <= !RR ? rr : int'(g) == PORTS - 1 ? '0 : g + 1'b1;
      end
    end
endmodule

// File: tb/tb_sdram_mp_arbiter.sv
// tb_sdram_mp_arbiter: directed and randomized checks of the arbiter against a
// transaction-level model of the grant order, beat contents and completion timing.
module tb_sdram_mp_arbiter;
  localparam int P = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [P-1:0] req, we, ack, gnt;
  logic [P*32-1:0] adr, wdat;
  logic [P*4-1:0] sel;
  logic [31:0] rdat, s_adr;
  logic idle, s_acc, s_we, s_ack;
  logic [15:0] s_wd, s_rd;
  logic [1:0] s_sel;
  logic [P-1:0] f_req, f_ack, f_gnt;
  logic [31:0] f_rdat, f_adr;
  logic f_acc, f_we;
  logic [15:0] f_dat;
  logic [1:0] f_sel;
  int checks = 0, errors = 0, cyc = 0;

  sdram_mp_arbiter #(.PORTS(P), .ARB_MODE("RR")) u_rr (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .req_i(req), .we_i(we), .adr_i(adr),
    .wdat_i(wdat), .sel_i(sel), .ack_o(ack), .rdat_o(rdat), .gnt_o(gnt),
    .idle_i(idle), .acc_o(s_acc), .we_o(s_we), .adr_o(s_adr), .dat_o(s_wd),
    .sel_o(s_sel), .ack_i(s_ack), .dat_i(s_rd));

  sdram_mp_arbiter #(.PORTS(P), .ARB_MODE("FIXED")) u_fix (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .req_i(f_req), .we_i('0), .adr_i('0),
    .wdat_i('0), .sel_i('0), .ack_o(f_ack), .rdat_o(f_rdat), .gnt_o(f_gnt),
    .idle_i(1'b1), .acc_o(f_acc), .we_o(f_we), .adr_o(f_adr), .dat_o(f_dat),
    .sel_o(f_sel), .ack_i(f_acc), .dat_i(16'h0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input int waits, input logic [15:0] d);
    s_ack = 1'b0;
    repeat (waits) step();
    s_ack = 1'b1;
    s_rd = d;
    step();
    s_ack = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    check(tag, {ack, gnt, s_acc, s_we, s_adr, s_wd, s_sel}, '0);
    check({tag, "_rdat"}, rdat, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, w, p, beats, completed, rr_m;
    bit active, prev_acc, prev_resp, should_start, got;
    logic t_we;
    logic [31:0] t_adr, t_wd, exp_rd, last_rdat;
    logic [3:0] t_sel, exp_ack;
    req = '0; we = '0; adr = '0; wdat = '0; sel = '0;
    idle = 1'b1; s_ack = 1'b0; s_rd = '0; f_req = '0;
    #3 rst_n = 1'b0;
    #1 outs_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();
    outs_zero("post_reset");
    // single write from port 2, immediate beat acks
    req[2] = 1'b1; we[2] = 1'b1; adr[64 +: 32] = 32'h0000_1004;
    wdat[64 +: 32] = 32'hA5A5_1234; sel[8 +: 4] = 4'b1101;
    step();
    check("wr_b0", {s_acc, s_we, gnt, s_adr, s_wd, s_sel}, {1'b1, 1'b1, 4'b0100, 32'h1004, 16'hA5A5, 2'b11});
    wdat[64 +: 32] = 32'h0; sel[8 +: 4] = 4'h0;
    beat(0, 16'h0);
    check("wr_b1", {s_acc, s_we, s_adr, s_wd, s_sel}, {1'b1, 1'b1, 32'h1006, 16'h1234, 2'b01});
    beat(0, 16'h0);
    check("wr_ack", {ack, gnt, s_acc, s_we}, {4'b0100, 4'b0100, 2'b00});
    check("wr_rdat", rdat, 32'h0);
    req = '0;
    step();
    check("wr_done", {ack, gnt}, 8'h0);
    // read from port 0 with two wait cycles per beat
    req[0] = 1'b1; we[0] = 1'b0; adr[0 +: 32] = 32'h20; sel[0 +: 4] = 4'hF;
    c0 = cyc;
    step();
    check("rd_b0", {s_acc, s_we, gnt, s_adr}, {1'b1, 1'b0, 4'b0001, 32'h20});
    beat(2, 16'hDEAD);
    check("rd_b1", {s_acc, s_adr}, {1'b1, 32'h22});
    beat(2, 16'hBEEF);
    check("rd_ack", {ack, rdat}, {4'b0001, 32'hDEAD_BEEF});
    check("rd_lat", cyc - c0, 7);
    req = '0;
    s_ack = 1'b1;
    step(); step();
    check("stray_ack", {s_acc, ack, gnt}, 9'h0);
    s_ack = 1'b0;
    // idle_i held low blocks the start
    req[0] = 1'b1; idle = 1'b0;
    repeat (10) begin
      step();
      check("idle_hold", s_acc, 1'b0);
    end
    idle = 1'b1;
    step();
    check("idle_go", s_acc, 1'b1);
    beat(0, 16'h1111);
    check("rst_b1", {s_acc, s_adr[1]}, 2'b11);
    rst_n = 1'b0;
    #1 outs_zero("rst_mid");
    req = '0;
    step(); step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("rst_no_ack", {ack, s_acc}, 5'h0);
    end
    // randomized traffic against a transaction-level model
    rr_m = 0; active = 0; prev_acc = 0; prev_resp = 0; completed = 0; beats = 0; w = 0;
    last_rdat = 32'h0; exp_rd = 32'h0; t_we = 0; t_adr = 0; t_wd = 0; t_sel = 0;
    for (int c = 0; c < 4300 && !(c >= 4000 && !active && req == '0); c++) begin
      should_start = !active && !prev_resp && idle && |req;
      step();
      check("start", s_acc && !prev_acc, should_start);
      if (should_start) begin
        got = 0;
        for (int i = 0; i < P; i++) begin
          p = (rr_m + i) % P;
          if (req[p] && !got) begin w = p; got = 1; end
        end
        t_we = we[w]; t_adr = {adr[w*32+2 +: 30], 2'b00};
        t_wd = wdat[w*32 +: 32]; t_sel = sel[w*4 +: 4];
        active = 1; beats = 0;
      end else if (active && prev_acc && s_ack) begin
        if (beats == 0) exp_rd[31:16] = s_rd;
        else exp_rd[15:0] = s_rd;
        beats++;
      end
      exp_ack = active && beats == 2 ? 4'(1) << w : 4'h0;
      check("ack", ack, exp_ack);
      check("gnt", gnt, active ? 4'(1) << w : 4'h0);
      if (active && beats < 2)
        check("beat", {s_acc, s_we, s_adr, s_wd, s_sel},
              {1'b1, t_we, t_adr[31:2], beats == 1, 1'b0,
               beats == 1 ? t_wd[15:0] : t_wd[31:16], beats == 1 ? t_sel[1:0] : t_sel[3:2]});
      if (exp_ack != 0) begin
        check("resp_acc", {s_acc, s_we}, 2'b00);
        if (!t_we) last_rdat = exp_rd;
        check("rdat", rdat, last_rdat);
        rr_m = (w + 1) % P; req[w] = 1'b0; active = 0; completed++;
      end else if (!active) check("acc_idle", s_acc, 1'b0);
      prev_resp = exp_ack != 0;
      prev_acc = s_acc;
      for (int i = 0; i < P; i++)
        if (!req[i] && c < 4000 && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      we = P'($urandom);
      adr = {$urandom, $urandom, $urandom, $urandom};
      wdat = {$urandom, $urandom, $urandom, $urandom};
      sel = 16'($urandom);
      idle = c >= 4000 || $urandom_range(0, 4) != 0;
      s_rd = 16'($urandom);
      s_ack = active && beats < 2 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 7) == 0;
    end
    check("drain", {active, req}, 5'h0);
    check("progress", completed > 100, 1'b1);
    // fixed priority: port 1 always beats port 3 while it keeps requesting
    s_ack = 1'b0;
    f_req = 4'b1010;
    c0 = 0;
    for (int c = 0; c < 60 && c0 < 5; c++) begin
      step();
      check("fix_gnt", f_gnt == 4'b0000 || f_gnt == 4'b0010, 1'b1);
      if (|f_ack) begin
        check("fix_p1", f_ack, 4'b0010);
        c0++;
      end
    end
    check("fix_count", c0, 5);
    f_req = 4'b1000;
    c0 = 0;
    for (int c = 0; c < 10 && c0 == 0; c++) begin
      step();
      if (|f_ack) begin
        check("fix_p3", f_ack, 4'b1000);
        c0++;
      end
    end
    check("fix_p3_seen", c0, 1);
    f_req = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
